mac_result_tx: RTL and testbench

//  Transmit side of the MAC coprocessor CV-X-IF result interface. Accepts completed MAC results
//  (id, 32-bit data, rd, write-enable) from the MAC datapath, buffers them in order, and presents

---
 rtl/mac_result_tx.sv | 114 +++++++++++
 tb/tb_mac_result_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_tx.sv
// Transmit side of the MAC coprocessor CV-X-IF result interface: an in-order
// result queue feeding the x_result valid/ready channel, with full/overflow back-pressure.

package cvxif_pkg;
  localparam int unsigned X_ID_WIDTH = 4;
endpackage

module mac_result_tx
  import cvxif_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = X_ID_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [ID_WIDTH-1:0]        push_id_i,
  input  logic [31:0]                push_data_i,
  input  logic [4:0]                 push_rd_i,
  input  logic                       push_we_i,
  output logic                       full_o,
  output logic                       overflow_o,
  input  logic                       flush_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_WIDTH-1:0]        result_id_o,
  output logic [31:0]                result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ID_WIDTH + 32 + 5 + 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             valid_q, valid_n;
  logic             full_q, full_n;
  logic             overflow_q;
  logic [ENT_W-1:0] head_q, head_n;
  logic [ENT_W-1:0] push_ent;
  logic             do_push, do_pop;

  assign push_ent = {push_id_i, push_data_i, push_rd_i, push_we_i};
  assign do_push  = push_i && !full_q && !flush_i;
  assign do_pop   = valid_q && result_ready_i && !flush_i;

  // Next occupancy plus a pre-computed head so every output leaves a flop.
  always_comb begin
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    count_n  = count_q;
    head_n   = '0;
    if (flush_i) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (do_push) wr_ptr_n = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_n = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_n = count_q + CNT_W'(1);
        2'b01:   count_n = count_q - CNT_W'(1);
        default: count_n = count_q;
      endcase
    end
    valid_n = (count_n != '0);
    full_n  = (count_n == CNT_W'(DEPTH));
    // A freshly pushed entry becomes head when it lands exactly at the new read slot.
    if (valid_n) begin
      if (do_push && (wr_ptr_q == rd_ptr_n)) head_n = push_ent;
      else                                   head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_n;
      rd_ptr_q   <= rd_ptr_n;
      count_q    <= count_n;
      valid_q    <= valid_n;
      full_q     <= full_n;
      overflow_q <= push_i && full_q;
      head_q     <= head_n;
    end
  end

  // Payload storage needs no reset; the head register masks it while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_ent;
  end

  assign full_o         = full_q;
  assign overflow_o     = overflow_q;
  assign result_valid_o = valid_q;
  assign count_o        = count_q;
  assign result_id_o    = head_q[ENT_W-1 -: ID_WIDTH];
  assign result_data_o  = head_q[37:6];
  assign result_rd_o    = head_q[5:1];
  assign result_we_o    = head_q[0];

endmodule

// File: tb/tb_mac_result_tx.sv
// Scoreboard bench for mac_result_tx: stimulus queues expected results, a negedge
// monitor pops them on each handshake and checks ordering, payload and stability.

module tb_mac_result_tx;
  localparam int unsigned IDW   = cvxif_pkg::X_ID_WIDTH;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic [4:0]     rd;
    logic           we;
  } res_t;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           push_i, push_we_i, flush_i, result_ready_i;
  logic [IDW-1:0] push_id_i;
  logic [31:0]    push_data_i;
  logic [4:0]     push_rd_i;
  logic           full_o, overflow_o, result_valid_o, result_we_o;
  logic [IDW-1:0] result_id_o;
  logic [31:0]    result_data_o;
  logic [4:0]     result_rd_o;
  logic [2:0]     count_o;

  int   checks = 0;
  int   errors = 0;
  int   mcount = 0;
  res_t exp_q[$];
  logic hold_v = 1'b0;
  res_t hold_p;

  mac_result_tx #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_i(push_i), .push_id_i(push_id_i), .push_data_i(push_data_i),
    .push_rd_i(push_rd_i), .push_we_i(push_we_i),
    .full_o(full_o), .overflow_o(overflow_o), .flush_i(flush_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the bench's own occupancy model predicts the flags.
  task automatic drive(input logic p, input logic [IDW-1:0] id, input logic [31:0] d,
                       input logic [4:0] rd, input logic we, input logic rdy, input logic fl);
    logic acc, pop, ovf;
    push_i = p; push_id_i = id; push_data_i = d; push_rd_i = rd; push_we_i = we;
    result_ready_i = rdy; flush_i = fl;
    ovf = p && (mcount == DEPTH);
    acc = p && !fl && (mcount != DEPTH);
    pop = !fl && rdy && (mcount != 0);
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (acc) exp_q.push_back('{id, d, rd, we});
      mcount = mcount + int'(acc) - int'(pop);
    end
    @(posedge clk_i); #1;
    push_i = 1'b0; flush_i = 1'b0;
    chk("count", 32'(count_o), 32'(mcount));
    chk("full", 32'(full_o), 32'(mcount == DEPTH));
    chk("valid", 32'(result_valid_o), 32'(mcount != 0));
    chk("overflow", 32'(overflow_o), 32'(ovf));
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, 32'h0, 5'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still expected", exp_q.size());
    end
  endtask

  // Monitor: pop and compare on every handshake; check holding while stalled.
  always @(negedge clk_i) begin
    res_t act, e;
    act = '{result_id_o, result_data_o, result_rd_o, result_we_o};
    if (!rst_ni) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!result_valid_o || act !== hold_p) begin
          errors++;
          $display("FAIL stable: got v=%0b %h expected v=1 %h", result_valid_o, act, hold_p);
        end
      end
      if (result_valid_o && result_ready_i && !flush_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h expected none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL result: got id=%0h data=%h rd=%0d we=%0b expected id=%0h data=%h rd=%0d we=%0b",
                     act.id, act.data, act.rd, act.we, e.id, e.data, e.rd, e.we);
          end
        end
      end
      hold_v = result_valid_o && !result_ready_i && !flush_i;
      hold_p = act;
    end
  end

  initial begin
    int sent;
    int guard;
    rst_ni = 1'b0; push_i = 1'b0; push_id_i = '0; push_data_i = '0; push_rd_i = '0;
    push_we_i = 1'b0; flush_i = 1'b0; result_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset state
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_data", result_data_o, 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);

    // Single push with ready already high: visible next cycle, then pops
    drive(1'b1, IDW'(2), 32'hDEADBEEF, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("t2_data", result_data_o, 32'hDEADBEEF);
    chk("t2_rd", 32'(result_rd_o), 32'd5);
    idle(1'b1);

    // Fill, overflow with id=1, then drain in order
    for (int i = 0; i < 4; i++)
      drive(1'b1, IDW'(i), 32'h1000_0000 + 32'(i), 5'(i + 8), i[0], 1'b0, 1'b0);
    drive(1'b1, IDW'(1), 32'hBAD0_0005, 5'd31, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // Full with simultaneous push and ready: pop wins, push rejected
    for (int i = 0; i < 4; i++)
      drive(1'b1, IDW'(i + 4), 32'h2000_0000 + 32'(i), 5'(i), 1'b1, 1'b0, 1'b0);
    drive(1'b1, IDW'(7), 32'hBAD0_0007, 5'd7, 1'b0, 1'b1, 1'b0);
    chk("t4_count", 32'(count_o), 32'd3);
    drain();

    // Stream 10 results with ready toggling; pointers wrap several times
    sent = 0; guard = 0;
    while (sent < 10 && guard < 60) begin
      if (mcount < DEPTH) begin
        drive(1'b1, IDW'(sent), 32'h3000_0000 ^ (32'(sent) * 32'h0101_0101), 5'(sent * 3),
              sent[0], guard[0] == 1'b0, 1'b0);
        sent++;
      end else begin
        idle(guard[0] == 1'b0);
      end
      guard++;
    end
    chk("t5_sent", 32'(sent), 32'd10);
    drain();

    // Flush beats a same-cycle push; the next push appears alone
    for (int i = 0; i < 3; i++)
      drive(1'b1, IDW'(i + 10), 32'h4000_0000 + 32'(i), 5'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, IDW'(9), 32'hBAD0_0009, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("t6_count", 32'(count_o), 32'd0);
    drive(1'b1, IDW'(5), 32'h5555_AAAA, 5'd17, 1'b1, 1'b0, 1'b0);
    chk("t6_data", result_data_o, 32'h5555_AAAA);
    drain();

    // Asynchronous reset mid-transfer clears everything without a handshake
    drive(1'b1, IDW'(3), 32'h6000_0001, 5'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, IDW'(4), 32'h6000_0002, 5'd2, 1'b1, 1'b0, 1'b0);
    result_ready_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(result_valid_o), 32'd0);
    chk("arst_count", 32'(count_o), 32'd0);
    exp_q.delete();
    mcount = 0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    idle(1'b1);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
